baud_generator: RTL and testbench
=================================

// Module: baud_generator
// PURPOSE
//  Bit-timing engine for the UART receive path. Detects a start bit, re-times to bit centres
//  and emits one rising edge on budclk per data bit. The parent UART receiver shifts its data
//  register on each such edge. Reports busy/idle on status and end-of-frame on finish.
//  Clocked by sysclk; sits between the RX pin (already inverted by parent) and the shift register.
// PARAMETERS
//  CLK_FREQ   100_000_000  sysclk frequency, Hz
//  BAUD       9600         line rate, bit/s; BIT_CYCLES=CLK_FREQ/BAUD (>=4), HALF_CYCLES=BIT_CYCLES/2
//  DATA_BITS  8            data bits per frame (LSB first), no parity, 1 stop bit
// PORTS
//  sysclk     in   1  system clock; all logic on posedge
//  reset      in   1  synchronous, active-high reset
//  enable     in   1  1=receive allowed; 0=hold/abort to IDLE
//  rx_active  in   1  inverted RX line (1 = line low = start/space); asynchronous
//  status     out  1  1=IDLE/ready, 0=frame in progress
//  finish     out  1  one-cycle pulse: valid stop bit sampled
//  budclk     out  1  bit strobe: rises at centre of each data bit, high HALF_CYCLES cycles
//  frame_err  out  1  only with UART_FRAME_ERR_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (reset=1 at posedge): state IDLE, counters 0, status=1, finish=0, budclk=0,
//    synchronizer flops 0.
//  - rx_active passes a 2-flop synchronizer -> rx_s. All timing below refers to rx_s
//    (2-cycle latency).
//  - FSM states: IDLE, START, DATA, STOP. status = (state==IDLE), registered.
//  - IDLE: if enable && rx_s==1 -> START, cnt=0.
//  - START: cnt counts to HALF_CYCLES-1.
//    - rx_s==1 there: DATA, cnt=0, bit=0.
//    - rx_s==0 there (glitch / false start): IDLE, no pulses.
//  - DATA: cnt counts 0..BIT_CYCLES-1; on wrap: budclk<=1, bit++.
//    - budclk<=0 when cnt reaches HALF_CYCLES-1 after the rise.
//    - After DATA_BITS strobes: STOP, cnt=0.
//  - STOP: at cnt==BIT_CYCLES-1 (stop-bit centre):
//    - rx_s==0 (line high): finish=1 for exactly one cycle.
//    - Either way: -> IDLE; status rises the same cycle.
//  - New start accepted from IDLE on the cycle after status rises (back-to-back frames supported).
//  - enable=0 in any state: next cycle IDLE, budclk=0, finish=0, counters cleared; enable ignored
//    on the cycle reset=1.
//  - reset mid-frame: identical to reset from idle; no finish, budclk forced 0.
//  - Counter widths: $clog2(BIT_CYCLES) for cnt, $clog2(DATA_BITS+1) for bit; no wrap beyond limits.
//  - budclk and finish never both high; exactly DATA_BITS budclk rises per accepted frame.
// CONFIGURATION
//  UART_FRAME_ERR_EN defined: port frame_err exists.
//    - One-cycle pulse at stop-bit centre when rx_s==1 (invalid stop); finish stays 0.
//    - Cleared by reset.
//  Undefined: no frame_err port; invalid stop silently returns to IDLE without finish.
// TESTING (CLK_FREQ=16, BAUD=1 -> BIT_CYCLES=16, HALF_CYCLES=8)
//  - reset=1 for 3 cycles -> status=1, finish=0, budclk=0 (with macro: frame_err=0).
//  - Frame 0x55 (rx_active=~line, 16 cycles/bit, valid stop):
//    - 8 budclk rises spaced 16 cycles, first ~26 cycles after rx_active rises.
//    - status=0 throughout; finish one-cycle pulse at stop centre; status=1 next.
//  - rx_active high for 4 cycles only (glitch) -> no budclk, no finish, status back to 1
//    within 12 cycles.
//  - Frame with stop bit low (rx_active=1) -> 8 budclk rises, finish never 1.
//    - With UART_FRAME_ERR_EN: frame_err=1 for exactly 1 cycle.
//  - enable dropped after 3rd budclk -> next cycle status=1, budclk=0; no further strobes;
//    next frame received normally.
//  - Two back-to-back frames 0xA3, 0x0F, no idle gap -> 16 budclk rises, two finish pulses
//    160 cycles apart.

Source files
------------

// File: rtl/baud_generator.sv
// UART receive bit-timing engine: start detect, bit-centre strobes, stop check.
// Optional frame_err output enabled with `define UART_FRAME_ERR_EN.
module baud_generator #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic sysclk,
    input  logic reset,
    input  logic enable,
    input  logic rx_active,
    output logic status,
    output logic finish,
    output logic budclk
`ifdef UART_FRAME_ERR_EN
    ,
    output logic frame_err
`endif
);

    localparam int BIT_CYCLES  = CLK_FREQ / BAUD;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF_CYCLES - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] LAST    = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bits;
    logic          s1;
    logic          rx_s;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            s1     <= 1'b0;
            rx_s   <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
            bits   <= '0;
            status <= 1'b1;
            finish <= 1'b0;
            budclk <= 1'b0;
`ifdef UART_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
        end else begin
            s1     <= rx_active;
            rx_s   <= s1;
            finish <= 1'b0;
`ifdef UART_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            if (!enable) begin
                state  <= IDLE;
                cnt    <= '0;
                bits   <= '0;
                status <= 1'b1;
                budclk <= 1'b0;
            end else begin
                // strobe falls half a bit after its rise, whatever the state
                if (budclk && cnt == HALF_M1)
                    budclk <= 1'b0;
                unique case (state)
                    IDLE: begin
                        if (rx_s) begin
                            state  <= START;
                            cnt    <= '0;
                            status <= 1'b0;
                        end
                    end
                    START: begin
                        if (cnt == HALF_M1) begin
                            cnt  <= '0;
                            bits <= '0;
                            if (rx_s) begin
                                state <= DATA;
                            end else begin
                                state  <= IDLE;
                                status <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DATA: begin
                        if (cnt == BIT_M1) begin
                            cnt    <= '0;
                            budclk <= 1'b1;
                            bits   <= bits + BW'(1);
                            if (bits == LAST)
                                state <= STOP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    STOP: begin
                        if (cnt == BIT_M1) begin
                            cnt    <= '0;
                            state  <= IDLE;
                            status <= 1'b1;
                            if (!rx_s)
                                finish <= 1'b1;
`ifdef UART_FRAME_ERR_EN
                            else
                                frame_err <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_baud_generator.sv
// Scoreboard bench for baud_generator at 16 cycles per bit.
// Event times are predicted from each frame's start cycle.
module tb_baud_generator;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic rx_active;
    logic status;
    logic finish;
    logic budclk;
`ifdef UART_FRAME_ERR_EN
    logic frame_err;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t exp_q[$];

    baud_generator #(
        .CLK_FREQ (16),
        .BAUD     (1),
        .DATA_BITS(8)
    ) dut (
        .sysclk   (clk),
        .reset    (reset),
        .enable   (enable),
        .rx_active(rx_active),
        .status   (status),
        .finish   (finish),
        .budclk   (budclk)
`ifdef UART_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic take_ev(input int k);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_ev", k, -1);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", k, e.kind);
            chk("ev_cyc", cyc, e.at);
        end
    endtask

    logic prev_b = 1'b0;
    int hi = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (budclk && !prev_b)
                take_ev(0);
            if (!budclk && prev_b && enable)
                chk("bud_width", hi, 8);
            if (finish) begin
                take_ev(1);
                chk("bud_fin_excl", int'(budclk), 0);
            end
`ifdef UART_FRAME_ERR_EN
            if (frame_err)
                take_ev(2);
`endif
        end
        hi = budclk ? (prev_b ? hi + 1 : 1) : 0;
        prev_b = budclk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // abort_n > 0 drops enable right after that many strobes
    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input int abort_n);
        int c;
        int n;
        int ab;
        logic [9:0] line;
        ev_t e;
        c = cyc;
        line = {stop_ok, d, 1'b0};
        n = (abort_n != 0) ? abort_n : 8;
        ab = 27 + 16 * (abort_n - 1);
        for (int i = 0; i < n; i++) begin
            e.kind = 0;
            e.at = c + 27 + 16 * i;
            exp_q.push_back(e);
        end
        if (abort_n == 0) begin
            if (stop_ok) begin
                e.kind = 1;
                e.at = c + 155;
                exp_q.push_back(e);
            end
`ifdef UART_FRAME_ERR_EN
            else begin
                e.kind = 2;
                e.at = c + 155;
                exp_q.push_back(e);
            end
`endif
        end
        for (int k = 0; k < 160; k++) begin
            rx_active = ~line[k / 16];
            if (abort_n != 0 && k == ab)
                enable = 1'b0;
            if (abort_n != 0 && k == ab + 1) begin
                chk("abort_status", int'(status), 1);
                chk("abort_budclk", int'(budclk), 0);
            end
            if (abort_n == 0 && k == 80)
                chk("mid_status", int'(status), 0);
            if (abort_n == 0 && stop_ok && k == 156)
                chk("end_status", int'(status), 1);
            tick(1);
        end
        enable = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        rx_active = 1'b0;
        tick(3);
        chk("rst_status", int'(status), 1);
        chk("rst_finish", int'(finish), 0);
        chk("rst_budclk", int'(budclk), 0);
`ifdef UART_FRAME_ERR_EN
        chk("rst_frame_err", int'(frame_err), 0);
`endif
        reset = 1'b0;
        tick(5);

        send_frame(8'h55, 1'b1, 0);
        rx_active = 1'b0;
        tick(10);

        rx_active = 1'b1;
        tick(4);
        chk("glitch_busy", int'(status), 0);
        rx_active = 1'b0;
        tick(10);
        chk("glitch_idle", int'(status), 1);
        tick(4);

        send_frame(8'h3C, 1'b0, 0);
        rx_active = 1'b0;
        tick(20);
        chk("bad_stop_idle", int'(status), 1);

        send_frame(8'h96, 1'b1, 3);
        rx_active = 1'b0;
        tick(5);
        send_frame(8'h5A, 1'b1, 0);
        rx_active = 1'b0;
        tick(5);

        send_frame(8'hA3, 1'b1, 0);
        send_frame(8'h0F, 1'b1, 0);
        rx_active = 1'b0;
        tick(20);

        chk("q_left", exp_q.size(), 0);
        chk("final_status", int'(status), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
